// File: rtl/ctrl_sequencer.sv
// Hardwired opcode-driven control sequencer: fetch, decode, per-class execute with memory wait/timeout.
// Optional single-step mode (run/step_req ports, STALL state) is built when CTRL_SINGLE_STEP_EN is defined.
module ctrl_sequencer #(
  parameter int                  OPCODE_W    = 5,
  parameter int                  MEM_TIMEOUT = 16,
  parameter logic [OPCODE_W-1:0] OP_ADD      = OPCODE_W'(5'b00011)
) (
  input  logic                clock,
  input  logic                clear,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic                run,
  input  logic                step_req,
`endif
  input  logic [OPCODE_W-1:0] ir_opcode,
  input  logic                mem_ready,
  output logic                Gra, Grb, Grc, Rin, Rout, BAout, Cout,
  output logic                PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout, Read, Write,
  output logic                Yin, Zin, Zlowout,
  output logic [OPCODE_W-1:0] alu_op,
  output logic [3:0]          step,
  output logic                halted,
  output logic                bus_error,
  output logic                illegal
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [OPCODE_W-1:0] OPC_LD     = OPCODE_W'(5'b00000);
  localparam logic [OPCODE_W-1:0] OPC_LDI    = OPCODE_W'(5'b00001);
  localparam logic [OPCODE_W-1:0] OPC_ST     = OPCODE_W'(5'b00010);
  localparam logic [OPCODE_W-1:0] OPC_ALU_LO = OPCODE_W'(5'b00011);
  localparam logic [OPCODE_W-1:0] OPC_ALU_HI = OPCODE_W'(5'b01011);
  localparam logic [OPCODE_W-1:0] OPC_ADDI   = OPCODE_W'(5'b01100);
  localparam logic [OPCODE_W-1:0] OPC_ANDI   = OPCODE_W'(5'b01101);
  localparam logic [OPCODE_W-1:0] OPC_ORI    = OPCODE_W'(5'b01110);
  localparam logic [OPCODE_W-1:0] OPC_NOP    = OPCODE_W'(5'b11010);
  localparam logic [OPCODE_W-1:0] OPC_HALT   = OPCODE_W'(5'b11011);
  localparam logic [OPCODE_W-1:0] ALU_ADD    = OPCODE_W'(5'b00011);
  localparam logic [OPCODE_W-1:0] ALU_AND    = OPCODE_W'(5'b00101);
  localparam logic [OPCODE_W-1:0] ALU_OR     = OPCODE_W'(5'b00110);

  // State values double as the externally visible step encoding.
  typedef enum logic [3:0] {
    S_RST   = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_T7    = 4'd8,
    S_STALL = 4'd14,
    S_HALT  = 4'd15
  } state_t;

  state_t                state, next, done_state;
  logic [CNT_W-1:0]      wait_cnt;
  logic                  mem_hold, timeout;
  logic                  is_ld, is_ldi, is_st, is_addr, is_alu, is_imm, is_nop, is_halt;
  logic [OPCODE_W-1:0]   imm_op;

  assign is_ld   = (ir_opcode == OPC_LD);
  assign is_ldi  = (ir_opcode == OPC_LDI);
  assign is_st   = (ir_opcode == OPC_ST);
  assign is_addr = is_ld | is_ldi | is_st;
  assign is_alu  = (ir_opcode >= OPC_ALU_LO) && (ir_opcode <= OPC_ALU_HI);
  assign is_imm  = (ir_opcode == OPC_ADDI) || (ir_opcode == OPC_ANDI) || (ir_opcode == OPC_ORI);
  assign is_nop  = (ir_opcode == OPC_NOP);
  assign is_halt = (ir_opcode == OPC_HALT);
  assign imm_op  = (ir_opcode == OPC_ANDI) ? ALU_AND : (ir_opcode == OPC_ORI) ? ALU_OR : ALU_ADD;
  assign step    = state;

`ifdef CTRL_SINGLE_STEP_EN
  logic step_req_q, step_rise;
  always_ff @(posedge clock or posedge clear) begin
    if (clear) step_req_q <= 1'b0;
    else       step_req_q <= step_req;
  end
  assign step_rise = step_req & ~step_req_q;
`endif

  always_comb begin
    {Gra, Grb, Grc, Rin, Rout, BAout, Cout} = '0;
    {PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout, Read, Write} = '0;
    {Yin, Zin, Zlowout} = '0;
    alu_op   = '0;
    illegal  = 1'b0;
    halted   = 1'b0;
    next     = state;
`ifdef CTRL_SINGLE_STEP_EN
    done_state = run ? S_T0 : S_STALL;
`else
    done_state = S_T0;
`endif
    case (state)
      S_RST: next = S_T0;
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; alu_op = OP_ADD;
        next = S_T1;
      end
      S_T1: begin
        Zlowout = 1'b1; Read = 1'b1; MDRin = 1'b1;
        PCin = mem_ready;
        if (mem_ready) next = S_T2;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1; next = S_T3;
      end
      S_T3: begin
        next = done_state;
        if (is_addr) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; next = S_T4;
        end else if (is_alu || is_imm) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; next = S_T4;
        end else if (is_halt) begin
          next = S_HALT;
        end else if (!is_nop) begin
          illegal = 1'b1;
        end
      end
      S_T4: begin
        next = S_T5;
        if (is_alu) begin
          Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = ir_opcode;
        end else if (is_imm) begin
          Cout = 1'b1; Zin = 1'b1; alu_op = imm_op;
        end else if (is_addr) begin
          Cout = 1'b1; Zin = 1'b1; alu_op = OP_ADD;
        end else begin
          next = done_state;
        end
      end
      S_T5: begin
        next = done_state;
        if (is_ld || is_st) begin
          Zlowout = 1'b1; MARin = 1'b1; next = S_T6;
        end else if (is_ldi || is_alu || is_imm) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end
      end
      S_T6: begin
        next = done_state;
        if (is_ld) begin
          Read = 1'b1; MDRin = 1'b1;
          next = mem_ready ? S_T7 : S_T6;
        end else if (is_st) begin
          Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; next = S_T7;
        end
      end
      S_T7: begin
        next = done_state;
        if (is_ld) begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (is_st) begin
          Write = 1'b1;
          if (!mem_ready) next = S_T7;
        end
      end
`ifdef CTRL_SINGLE_STEP_EN
      S_STALL: if (run || step_rise) next = S_T0;
`else
      S_STALL: next = S_T0;
`endif
      S_HALT: begin
        halted = 1'b1; next = S_HALT;
      end
      default: next = S_RST;
    endcase
    // A memory step that keeps waiting past the budget abandons the instruction.
    mem_hold = (Read | Write) & ~mem_ready;
    timeout  = mem_hold && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
    if (timeout) next = S_HALT;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state     <= S_RST;
      wait_cnt  <= '0;
      bus_error <= 1'b0;
    end else begin
      state    <= next;
      wait_cnt <= (mem_hold && !timeout) ? wait_cnt + CNT_W'(1) : '0;
      if (timeout) bus_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: per-opcode micro-step tables expanded with random memory delays,
// compared every cycle against step, strobes, alu_op, halted, illegal and bus_error.
module tb_ctrl_sequencer;

  localparam int MEM_TIMEOUT = 16;

  localparam logic [18:0] GRA   = 19'(1) << 18, GRB    = 19'(1) << 17, GRC    = 19'(1) << 16;
  localparam logic [18:0] RIN   = 19'(1) << 15, ROUT   = 19'(1) << 14, BAOUT  = 19'(1) << 13;
  localparam logic [18:0] COUT  = 19'(1) << 12, PCOUT  = 19'(1) << 11, PCIN   = 19'(1) << 10;
  localparam logic [18:0] INCPC = 19'(1) << 9,  IRIN   = 19'(1) << 8,  MARIN  = 19'(1) << 7;
  localparam logic [18:0] MDRIN = 19'(1) << 6,  MDROUT = 19'(1) << 5,  READ   = 19'(1) << 4;
  localparam logic [18:0] WRITE = 19'(1) << 3,  YIN    = 19'(1) << 2,  ZIN    = 19'(1) << 1;
  localparam logic [18:0] ZLOW  = 19'(1);

  logic clock = 1'b0;
  logic clear;
  logic [4:0] ir_opcode;
  logic mem_ready;
  logic Gra, Grb, Grc, Rin, Rout, BAout, Cout;
  logic PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout, Read, Write;
  logic Yin, Zin, Zlowout;
  logic [4:0] alu_op;
  logic [3:0] step;
  logic halted, bus_error, illegal;
`ifdef CTRL_SINGLE_STEP_EN
  logic run, step_req;
`endif

  always #5 clock = ~clock;

  ctrl_sequencer #(.OPCODE_W(5), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clock(clock), .clear(clear),
`ifdef CTRL_SINGLE_STEP_EN
    .run(run), .step_req(step_req),
`endif
    .ir_opcode(ir_opcode), .mem_ready(mem_ready),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .IRin(IRin), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .Read(Read), .Write(Write), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
    .alu_op(alu_op), .step(step), .halted(halted), .bus_error(bus_error), .illegal(illegal)
  );

  logic [18:0] obs_cw;
  assign obs_cw = {Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, PCin, IncPC, IRin, MARin,
                   MDRin, MDRout, Read, Write, Yin, Zin, Zlowout};

  typedef struct {
    logic [3:0]  st;
    logic [18:0] cw;
    logic [4:0]  alu;
    bit          mem;
    bit          ill;
  } ustep_t;

  ustep_t prog[$];
  int ncmp = 0;
  int nfail = 0;
  bit be;
  bit to;

  task automatic check(input string tag, input logic [3:0] est, input logic [18:0] ecw,
                       input logic [4:0] ealu, input bit eh, input bit ei);
    ncmp++; assert (step === est) else begin
      nfail++; $error("FAIL %s step got %0d exp %0d", tag, step, est); end
    ncmp++; assert (obs_cw === ecw) else begin
      nfail++; $error("FAIL %s strobes got %05h exp %05h", tag, obs_cw, ecw); end
    ncmp++; assert (alu_op === ealu) else begin
      nfail++; $error("FAIL %s alu_op got %0d exp %0d", tag, alu_op, ealu); end
    ncmp++; assert (halted === eh) else begin
      nfail++; $error("FAIL %s halted got %b exp %b", tag, halted, eh); end
    ncmp++; assert (illegal === ei) else begin
      nfail++; $error("FAIL %s illegal got %b exp %b", tag, illegal, ei); end
    ncmp++; assert (bus_error === be) else begin
      nfail++; $error("FAIL %s bus_error got %b exp %b", tag, bus_error, be); end
  endtask

  task automatic add(input logic [3:0] st, input logic [18:0] cw, input logic [4:0] alu,
                     input bit mem, input bit ill);
    ustep_t u;
    u.st = st; u.cw = cw; u.alu = alu; u.mem = mem; u.ill = ill;
    prog.push_back(u);
  endtask

  // Expected micro-steps of one instruction, straight from the opcode class tables.
  task automatic plan(input logic [4:0] op);
    int o;
    o = int'(op);
    prog.delete();
    add(1, PCOUT | MARIN | INCPC | ZIN, 5'd3, 0, 0);
    add(2, ZLOW | PCIN | READ | MDRIN, 0, 1, 0);
    add(3, MDROUT | IRIN, 0, 0, 0);
    if (o <= 2) begin
      add(4, GRB | BAOUT | YIN, 0, 0, 0);
      add(5, COUT | ZIN, 5'd3, 0, 0);
      if (o == 1) add(6, ZLOW | GRA | RIN, 0, 0, 0);
      else        add(6, ZLOW | MARIN, 0, 0, 0);
      if (o == 0) begin
        add(7, READ | MDRIN, 0, 1, 0);
        add(8, MDROUT | GRA | RIN, 0, 0, 0);
      end else if (o == 2) begin
        add(7, GRA | ROUT | MDRIN, 0, 0, 0);
        add(8, WRITE, 0, 1, 0);
      end
    end else if (o <= 14) begin
      add(4, GRB | ROUT | YIN, 0, 0, 0);
      if (o <= 11)      add(5, GRC | ROUT | ZIN, op, 0, 0);
      else if (o == 12) add(5, COUT | ZIN, 5'd3, 0, 0);
      else if (o == 13) add(5, COUT | ZIN, 5'd5, 0, 0);
      else              add(5, COUT | ZIN, 5'd6, 0, 0);
      add(6, ZLOW | GRA | RIN, 0, 0, 0);
    end else begin
      add(4, 0, 0, 0, (o != 26) && (o != 27));
    end
  endtask

  // Runs one instruction; dfetch/dexec are mem_ready delays for the first/second memory step.
  task automatic exec(input logic [4:0] op, input int dfetch, input int dexec,
                      input int abort_at, output bit timed_out);
    int memn;
    int d;
    plan(op);
    memn = 0;
    timed_out = 0;
    for (int i = 0; i < prog.size(); i++) begin
      if (prog[i].mem) begin
        d = (memn == 0) ? dfetch : dexec;
        memn++;
        for (int k = 0; k <= d; k++) begin
          @(negedge clock);
          mem_ready = (k == d);
          #1;
          check($sformatf("op%0d.s%0d.w%0d", op, prog[i].st, k), prog[i].st,
                (k == d) ? prog[i].cw : (prog[i].cw & ~PCIN), prog[i].alu, 1'b0, prog[i].ill);
          if (k != d && k == MEM_TIMEOUT - 1) begin
            be = 1;
            timed_out = 1;
            return;
          end
        end
      end else begin
        @(negedge clock);
        if (i == 3) ir_opcode = op;
        mem_ready = 1'($urandom_range(0, 1));
        #1;
        check($sformatf("op%0d.s%0d", op, prog[i].st), prog[i].st, prog[i].cw, prog[i].alu,
              1'b0, prog[i].ill);
      end
      if (i == abort_at) begin
        #2 clear = 1'b1;
        be = 0;
        #1;
        check("abort", 4'd0, 19'd0, 5'd0, 1'b0, 1'b0);
        return;
      end
    end
  endtask

  task automatic check_halt(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      check($sformatf("halt%0d", i), 4'd15, 19'd0, 5'd0, 1'b1, 1'b0);
    end
  endtask

  task automatic release_reset();
    @(negedge clock);
    clear = 1'b0;
    #1;
    check("rst_release", 4'd0, 19'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    clear = 1'b1;
    be = 0;
    #1;
    check("rst_assert", 4'd0, 19'd0, 5'd0, 1'b0, 1'b0);
    release_reset();
  endtask

`ifdef CTRL_SINGLE_STEP_EN
  task automatic stall_cycles(input int n, input bit sreq, input bit rv);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      step_req = sreq;
      run = rv;
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      check("stall", 4'd14, 19'd0, 5'd0, 1'b0, 1'b0);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] rop;
    clear = 1'b1;
    mem_ready = 1'b0;
    ir_opcode = 5'd0;
    be = 0;
`ifdef CTRL_SINGLE_STEP_EN
    run = 1'b1;
    step_req = 1'b0;
`endif
    @(negedge clock);
    #1;
    check("rst_hold", 4'd0, 19'd0, 5'd0, 1'b0, 1'b0);
    release_reset();

    exec(5'd0, 0, 0, -1, to);
    exec(5'd0, 3, 3, -1, to);
    exec(5'd3, 0, 0, -1, to);
    exec(5'd12, 0, 0, -1, to);
    exec(5'd13, 0, 0, -1, to);
    exec(5'd14, 0, 0, -1, to);
    exec(5'd1, 2, 0, -1, to);
    exec(5'd2, 1, 2, -1, to);
    exec(5'd31, 0, 0, -1, to);
    exec(5'd26, 0, 0, -1, to);

    for (int n = 0; n < 40; n++) begin
      rop = 5'($urandom_range(0, 31));
      if (rop == 5'd27) rop = 5'd11;
      exec(rop, $urandom_range(0, 4), $urandom_range(0, 4), -1, to);
    end

    exec(5'd0, 0, 1, 6, to);
    release_reset();
    exec(5'd1, 0, 0, -1, to);

    exec(5'd2, 0, 1000, -1, to);
    check_halt(20);
    do_reset();

    exec(5'd27, 0, 0, -1, to);
    check_halt(20);
    do_reset();
    exec(5'd3, 1, 0, -1, to);

`ifdef CTRL_SINGLE_STEP_EN
    do_reset();
    run = 1'b0;
    exec(5'd26, 0, 0, -1, to);
    stall_cycles(2, 1'b0, 1'b0);
    stall_cycles(1, 1'b1, 1'b0);
    exec(5'd3, 0, 0, -1, to);
    stall_cycles(3, 1'b1, 1'b0);
    stall_cycles(1, 1'b0, 1'b1);
    exec(5'd12, 0, 0, -1, to);
    exec(5'd26, 0, 0, -1, to);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
